// File: rtl/memory_sweep_clr.sv
// Single-port synchronous RAM with active-low CS/RD/WR access, registered read with a
// valid strobe, write-through on simultaneous RD/WR, and a hardware clear sweep.
module memory_sweep_clr #(
  parameter int                   BIT_DEPTH     = 8,
  parameter int                   ADDRESS_LINES = 7,
  parameter logic [BIT_DEPTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     CS,
  input  logic                     RD,
  input  logic                     WR,
  input  logic                     Clr,
  input  logic [ADDRESS_LINES-1:0] Add,
  input  logic [BIT_DEPTH-1:0]     Din,
  output logic [BIT_DEPTH-1:0]     Dout,
  output logic                     Dvalid,
  output logic                     Busy
);

  // state  | meaning
  // CLEAR  | sweeping CLEAR_VALUE into every location, bus ignored
  // IDLE   | serving bus reads/writes, Clr restarts the sweep
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam int DEPTH = 1 << ADDRESS_LINES;

  // One bit wider than the address so the last-location compare is exact.
  localparam logic [ADDRESS_LINES:0] PTR_LAST = {1'b0, {ADDRESS_LINES{1'b1}}};
  localparam logic [ADDRESS_LINES:0] PTR_ONE  = {{ADDRESS_LINES{1'b0}}, 1'b1};

  logic [BIT_DEPTH-1:0]     mem [DEPTH];
  logic [0:0]               state;
  logic [ADDRESS_LINES:0]   ptr;
  logic                     mem_we;
  logic [ADDRESS_LINES-1:0] mem_waddr;
  logic [BIT_DEPTH-1:0]     mem_wdata;
  logic                     bus_access;

  assign bus_access = (state == S_IDLE) && !Clr && !CS;
  assign Busy       = (state == S_CLEAR);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = Add;
    mem_wdata = Din;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr[ADDRESS_LINES-1:0];
      mem_wdata = CLEAR_VALUE;
    end else if (bus_access && !WR) begin
      mem_we = 1'b1;
    end
  end

  // The array has no reset; it is initialised by the sweep.
  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= S_CLEAR;
      ptr    <= '0;
      Dout   <= '0;
      Dvalid <= 1'b0;
    end else begin
      Dvalid <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (ptr == PTR_LAST) begin
            state <= S_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + PTR_ONE;
          end
        end
        S_IDLE: begin
          if (Clr) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end else if (!CS && !RD) begin
            // Write-through returns the incoming word rather than the stale one.
            Dout   <= !WR ? Din : mem[Add];
            Dvalid <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sweep_clr.sv
// Directed self-checking bench for memory_sweep_clr with hand-computed expectations.
module tb_memory_sweep_clr;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       CS, RD, WR, Clr;
  logic [6:0] Add;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       Dvalid;
  logic       Busy;

  int passed = 0;
  int total  = 0;

  memory_sweep_clr #(.BIT_DEPTH(8), .ADDRESS_LINES(7), .CLEAR_VALUE(8'h00)) dut (
    .Clk(Clk), .Rst(Rst), .CS(CS), .RD(RD), .WR(WR), .Clr(Clr),
    .Add(Add), .Din(Din), .Dout(Dout), .Dvalid(Dvalid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bus_idle();
    CS = 1'b1; RD = 1'b1; WR = 1'b1; Clr = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    CS = 1'b0; RD = 1'b1; WR = 1'b0; Add = a; Din = d;
    tick();
    bus_idle();
  endtask

  task automatic do_read(input string tag, input logic [6:0] a, input logic [7:0] exp);
    CS = 1'b0; RD = 1'b0; WR = 1'b1; Add = a;
    tick();
    bus_idle();
    chk({tag, "_dout"}, 32'(Dout), 32'(exp));
    chk({tag, "_dvalid"}, 32'(Dvalid), 32'd1);
    tick();
    chk({tag, "_pulse_end"}, 32'(Dvalid), 32'd0);
  endtask

  // Expects the next rising edge to be the first sweep write.
  task automatic sweep_len(input string tag);
    for (int i = 0; i < 127; i++) tick();
    chk({tag, "_busy_127"}, 32'(Busy), 32'd1);
    tick();
    chk({tag, "_busy_128"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    Rst = 1'b1; Add = '0; Din = '0;
    bus_idle();
    #2;
    chk("rst_dout", 32'(Dout), 32'h00);
    chk("rst_dvalid", 32'(Dvalid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd1);
    tick(); tick(); tick();
    Rst = 1'b0;

    // 1: reset sweep length, cleared read
    sweep_len("t1");
    do_read("t1_rd5", 7'd5, 8'h00);

    // 2: writes then back-to-back reads
    do_write(7'd0, 8'h35);
    do_write(7'd1, 8'h53);
    CS = 1'b0; RD = 1'b0; WR = 1'b1; Add = 7'd0;
    tick();
    chk("t2_rd0_dout", 32'(Dout), 32'h35);
    chk("t2_rd0_dvalid", 32'(Dvalid), 32'd1);
    Add = 7'd1;
    tick();
    bus_idle();
    chk("t2_rd1_dout", 32'(Dout), 32'h53);
    chk("t2_rd1_dvalid", 32'(Dvalid), 32'd1);
    tick();
    chk("t2_pulse_end", 32'(Dvalid), 32'd0);
    chk("t2_dout_hold", 32'(Dout), 32'h53);

    // 3: write-through
    CS = 1'b0; RD = 1'b0; WR = 1'b0; Add = 7'd1; Din = 8'hA5;
    tick();
    bus_idle();
    chk("t3_wt_dout", 32'(Dout), 32'hA5);
    chk("t3_wt_dvalid", 32'(Dvalid), 32'd1);
    tick();
    do_read("t3_rd1", 7'd1, 8'hA5);

    // 4: deselected write is a no-op
    CS = 1'b1; RD = 1'b1; WR = 1'b0; Add = 7'd0; Din = 8'hFF;
    tick();
    bus_idle();
    chk("t4_dvalid", 32'(Dvalid), 32'd0);
    chk("t4_dout_hold", 32'(Dout), 32'hA5);
    do_read("t4_rd0", 7'd0, 8'h35);

    // 5: clear request beats a same-cycle write; bus writes ignored during sweep
    Clr = 1'b1; CS = 1'b0; RD = 1'b1; WR = 1'b0; Add = 7'd2; Din = 8'h77;
    tick();
    Clr = 1'b0; Add = 7'd0; Din = 8'hEE;
    chk("t5_busy_rise", 32'(Busy), 32'd1);
    chk("t5_dvalid", 32'(Dvalid), 32'd0);
    for (int i = 0; i < 127; i++) tick();
    chk("t5_busy_127", 32'(Busy), 32'd1);
    tick();
    bus_idle();
    chk("t5_busy_128", 32'(Busy), 32'd0);
    chk("t5_dout_hold", 32'(Dout), 32'h35);
    do_read("t5_rd0", 7'd0, 8'h00);
    do_read("t5_rd1", 7'd1, 8'h00);
    do_read("t5_rd2", 7'd2, 8'h00);

    // 6: reset in the middle of a sweep restarts it from location 0
    do_write(7'd100, 8'h5A);
    do_read("t6_rd100", 7'd100, 8'h5A);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("t6_mid_busy", 32'(Busy), 32'd1);
    chk("t6_mid_dout_hold", 32'(Dout), 32'h5A);
    Rst = 1'b1;
    #1;
    chk("t6_rst_dout", 32'(Dout), 32'h00);
    chk("t6_rst_busy", 32'(Busy), 32'd1);
    #2;
    Rst = 1'b0;
    sweep_len("t6");
    do_read("t6_rd100_clr", 7'd100, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
